// File: rtl/mips_bus_access_unit_if.sv
// Requester-side and Avalon-MM-side signal bundle for mips_bus_access_unit.
// master = the bus access unit; slave = the requesters plus the Avalon slave.
interface mips_bus_access_unit_if #(
    parameter int N_PORTS = 2
);
    logic [N_PORTS-1:0]       req_valid;
    logic [N_PORTS-1:0]       req_ready;
    logic [N_PORTS-1:0][31:0] req_addr;
    logic [N_PORTS-1:0]       req_write;
    logic [N_PORTS-1:0][1:0]  req_size;
    logic [N_PORTS-1:0]       req_signed;
    logic [N_PORTS-1:0][31:0] req_wdata;
    logic [N_PORTS-1:0]       resp_valid;
    logic [31:0]              resp_rdata;
    logic                     resp_err;
    logic                     busy;
    logic [31:0]              address;
    logic                     read;
    logic                     write;
    logic                     waitrequest;
    logic [31:0]              writedata;
    logic [3:0]               byteenable;
    logic [31:0]              readdata;

    modport master (
        input  req_valid, req_addr, req_write, req_size, req_signed, req_wdata,
               waitrequest, readdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
               address, read, write, writedata, byteenable
    );

    modport slave (
        output req_valid, req_addr, req_write, req_size, req_signed, req_wdata,
               waitrequest, readdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
               address, read, write, writedata, byteenable
    );
endinterface

// File: rtl/mips_bus_access_unit.sv
// Round-robin multi-requester Avalon-MM master with byte/half/word sizing.
// Optional stall timeout enabled by defining BUS_TIMEOUT_EN.
module mips_bus_access_unit #(
    parameter int N_PORTS        = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_bus_access_unit_if.master bus
);
    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP, S_ERR} state_e;

    state_e             state_q;
    logic [PW-1:0]      ptr_q, owner_q;
    logic               write_q, signed_q;
    logic [1:0]         size_q, alo_q;
    logic [31:0]        address_q, writedata_q, resp_rdata_q;
    logic [3:0]         byteenable_q;
    logic               read_q, wr_strobe_q, resp_err_q;
    logic [N_PORTS-1:0] resp_valid_q;
`ifdef BUS_TIMEOUT_EN
    logic [31:0]        tmo_q;
`endif

    logic [PW-1:0]      grant, cand, ptr_d;
    logic [PW:0]        sum;
    logic               grant_vld;

    function automatic logic [3:0] calc_be(input logic [1:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    calc_be = 4'b0001 << a;
            2'd1:    calc_be = a[1] ? 4'b1100 : 4'b0011;
            default: calc_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [31:0] d, input logic [1:0] sz);
        case (sz)
            2'd0:    calc_wdata = {4{d[7:0]}};
            2'd1:    calc_wdata = {2{d[15:0]}};
            default: calc_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] a,
                                            input logic [1:0] sz, input logic sgn);
        logic [31:0] s;
        s = d >> {a, 3'b000};
        case (sz)
            2'd0:    extract = {{24{sgn & s[7]}}, s[7:0]};
            2'd1:    extract = {{16{sgn & s[15]}}, s[15:0]};
            default: extract = s;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = a[0];
            2'd2:    misaligned = |a;
            default: misaligned = 1'b1;
        endcase
    endfunction

    // Scan ports starting at ptr_q, wrapping; first valid one wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(N_PORTS)) sum = sum - (PW+1)'(N_PORTS);
            cand = sum[PW-1:0];
            if (!grant_vld && bus.req_valid[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
        sum = {1'b0, grant} + (PW+1)'(1);
        if (sum >= (PW+1)'(N_PORTS)) sum = '0;
        ptr_d = sum[PW-1:0];
    end

    always_comb begin
        bus.req_ready = '0;
        if (state_q == S_IDLE && grant_vld && !reset) bus.req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= '0;
            alo_q        <= '0;
            address_q    <= '0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            read_q       <= 1'b0;
            wr_strobe_q  <= 1'b0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
`ifdef BUS_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (grant_vld) begin
                    ptr_q    <= ptr_d;
                    owner_q  <= grant;
                    write_q  <= bus.req_write[grant];
                    signed_q <= bus.req_signed[grant];
                    size_q   <= bus.req_size[grant];
                    alo_q    <= bus.req_addr[grant][1:0];
                    if (misaligned(bus.req_addr[grant][1:0], bus.req_size[grant])) begin
                        state_q      <= S_ERR;
                        resp_valid_q <= N_PORTS'(1) << grant;
                        resp_err_q   <= 1'b1;
                    end else begin
                        state_q      <= S_BUS;
                        address_q    <= {bus.req_addr[grant][31:2], 2'b00};
                        read_q       <= !bus.req_write[grant];
                        wr_strobe_q  <= bus.req_write[grant];
                        byteenable_q <= calc_be(bus.req_addr[grant][1:0], bus.req_size[grant]);
                        writedata_q  <= calc_wdata(bus.req_wdata[grant], bus.req_size[grant]);
`ifdef BUS_TIMEOUT_EN
                        tmo_q        <= '0;
`endif
                    end
                end
                S_BUS: begin
                    if (!bus.waitrequest) begin
                        state_q      <= S_RESP;
                        read_q       <= 1'b0;
                        wr_strobe_q  <= 1'b0;
                        resp_valid_q <= N_PORTS'(1) << owner_q;
                        resp_rdata_q <= write_q ? 32'd0
                                                : extract(bus.readdata, alo_q, size_q, signed_q);
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
                        // Give up on a stuck slave and report it as an error.
                        state_q      <= S_ERR;
                        read_q       <= 1'b0;
                        wr_strobe_q  <= 1'b0;
                        resp_valid_q <= N_PORTS'(1) << owner_q;
                        resp_err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
`endif
                end
                default: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= '0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
            endcase
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.address    = address_q;
    assign bus.read       = read_q;
    assign bus.write      = wr_strobe_q;
    assign bus.writedata  = writedata_q;
    assign bus.byteenable = byteenable_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_mips_bus_access_unit.sv
// Directed plus randomized bench for mips_bus_access_unit against an
// arithmetic reference model of sizing, lane handling and round-robin order.
module tb_mips_bus_access_unit;
    localparam int NP = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_bus_access_unit_if #(.N_PORTS(NP)) bif ();
    mips_bus_access_unit #(.N_PORTS(NP), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .bus(bif)
    );

    int   checks = 0;
    int   errors = 0;
    logic rr_ptr;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] oh(input logic p);
        return p ? 32'd2 : 32'd1;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic m_err(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b1;
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] m_be(input logic [31:0] a, input logic [1:0] sz);
        int mask;
        mask = (1 << nbytes(sz)) - 1;
        return 32'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] m_wd(input logic [31:0] d, input logic [1:0] sz);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [1:0] sz, input logic sg);
        logic [31:0] mask, v;
        int nb;
        nb   = nbytes(sz);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = (rd >> (8 * (a % 4))) & mask;
        if (sg && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_strobes"}, 32'({bif.read, bif.write, bif.busy, bif.resp_err}), 32'd0);
        chk({tag, "_resp"}, 32'({bif.resp_valid, bif.req_ready}), 32'd0);
        chk({tag, "_addr"}, bif.address, 32'd0);
        chk({tag, "_wdata"}, bif.writedata, 32'd0);
        chk({tag, "_be_rdata"}, bif.resp_rdata | 32'(bif.byteenable), 32'd0);
    endtask

    // One full request from acceptance to return-to-idle; both=1 also raises
    // the other port, whose loss of arbitration the model predicts.
    task automatic do_txn(input logic p, input logic both, input logic [31:0] a, input logic w,
                          input logic [1:0] sz, input logic sg, input logic [31:0] d,
                          input int nwait, input logic [31:0] rd);
        logic [31:0] r;
        bif.req_addr[p]   = a;
        bif.req_write[p]  = w;
        bif.req_size[p]   = sz;
        bif.req_signed[p] = sg;
        bif.req_wdata[p]  = d;
        bif.req_valid     = both ? 2'b11 : 2'(oh(p));
        #1;
        chk("ready", 32'(bif.req_ready), oh(p));
        step();
        rr_ptr = ~p;
        bif.req_valid   = 2'b00;
        r = $urandom;
        bif.req_addr[p]  = r;
        bif.req_wdata[p] = ~r;
        chk("busy", 32'(bif.busy), 32'd1);
        if (m_err(a, sz)) begin
            chk("err_strobe", 32'({bif.read, bif.write}), 32'd0);
            chk("err_valid", 32'(bif.resp_valid), oh(p));
            chk("err_flag", 32'(bif.resp_err), 32'd1);
            chk("err_rdata", bif.resp_rdata, 32'd0);
            step();
            chk("err_done", 32'({bif.resp_valid, bif.busy, bif.resp_err}), 32'd0);
        end else begin
            for (int i = 0; i <= nwait; i++) begin
                chk("read", 32'(bif.read), 32'(!w));
                chk("write", 32'(bif.write), 32'(w));
                chk("addr", bif.address, a & ~32'd3);
                chk("be", 32'(bif.byteenable), m_be(a, sz));
                if (w) chk("wdata", bif.writedata, m_wd(d, sz));
                chk("no_resp", 32'(bif.resp_valid), 32'd0);
                bif.waitrequest = (i < nwait);
                r = $urandom;
                bif.readdata = (i < nwait) ? r : rd;
                step();
            end
            bif.waitrequest = 1'b0;
            chk("resp_valid", 32'(bif.resp_valid), oh(p));
            chk("resp_err", 32'(bif.resp_err), 32'd0);
            chk("rdata", bif.resp_rdata, w ? 32'd0 : m_rd(rd, a, sz, sg));
            chk("strobe_off", 32'({bif.read, bif.write}), 32'd0);
            step();
            chk("idle", 32'({bif.resp_valid, bif.busy}), 32'd0);
        end
    endtask

    initial begin
        int   ng;
        logic exp_g;
        logic [31:0] r, a, d, rd;
        logic p, both, w, sg;
        logic [1:0] sz;

        reset = 1'b1;
        bif.req_valid = '0; bif.req_addr = '0; bif.req_write = '0; bif.req_size = '0;
        bif.req_signed = '0; bif.req_wdata = '0; bif.waitrequest = 1'b0; bif.readdata = '0;
        step(); step();
        check_reset_outputs("por");
        reset = 1'b0;
        rr_ptr = 1'b0;

        // Reset in the middle of a read strobe.
        bif.req_addr[0] = 32'h40; bif.req_size[0] = 2'd2; bif.req_valid = 2'b01;
        step();
        bif.req_valid = 2'b00;
        bif.waitrequest = 1'b1;
        chk("mid_read_up", 32'(bif.read), 32'd1);
        reset = 1'b1;
        bif.req_valid = 2'b11;
        step();
        check_reset_outputs("mid_rst");
        step();
        check_reset_outputs("mid_rst2");
        reset = 1'b0;
        bif.req_valid = 2'b00;
        bif.waitrequest = 1'b0;
        rr_ptr = 1'b0;

        // Both ports requesting continuously must alternate starting at port 0.
        bif.req_addr[0] = 32'h100; bif.req_addr[1] = 32'h200;
        bif.req_size = {2'd2, 2'd2}; bif.req_write = 2'b00; bif.req_valid = 2'b11;
        #1;
        exp_g = rr_ptr;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            if (bif.req_ready != 2'b00) begin
                chk("grant", 32'(bif.req_ready), oh(exp_g));
                exp_g = ~exp_g;
                ng++;
            end
            step();
        end
        chk("grant_count", 32'(ng), 32'd4);
        bif.req_valid = 2'b00;
        for (int c = 0; c < 10 && bif.busy; c++) step();
        chk("grant_drain", 32'(bif.busy), 32'd0);
        rr_ptr = exp_g;

        do_txn(1'b0, 1'b0, 32'h1000, 1'b0, 2'd2, 1'b0, 32'h0, 0, 32'hDEADBEEF);
        do_txn(1'b1, 1'b0, 32'h1003, 1'b0, 2'd0, 1'b1, 32'h0, 0, 32'h8000_0000);
        do_txn(1'b1, 1'b0, 32'h1003, 1'b0, 2'd0, 1'b0, 32'h0, 0, 32'h8000_0000);
        do_txn(1'b1, 1'b0, 32'h2002, 1'b1, 2'd1, 1'b0, 32'h1234, 0, 32'h0);
        do_txn(1'b0, 1'b0, 32'h3004, 1'b0, 2'd2, 1'b0, 32'h0, 3, 32'h1234_5678);
        do_txn(1'b0, 1'b0, 32'h1002, 1'b0, 2'd2, 1'b0, 32'h0, 0, 32'h0);
        do_txn(1'b1, 1'b0, 32'h1001, 1'b0, 2'd1, 1'b1, 32'h0, 0, 32'h0);
        do_txn(1'b0, 1'b0, 32'h1000, 1'b1, 2'd3, 1'b0, 32'h0, 0, 32'h0);
        do_txn(1'b0, 1'b0, 32'h2002, 1'b0, 2'd1, 1'b1, 32'h0, 1, 32'h9ABC_0000);
        do_txn(1'b1, 1'b0, 32'h2001, 1'b1, 2'd0, 1'b0, 32'hA5, 2, 32'h0);

        // Randomized mix, sometimes with both ports contending.
        for (int n = 0; n < 60; n++) begin
            r = $urandom;
            both = r[0];
            p    = both ? rr_ptr : r[1];
            w    = r[2];
            sg   = r[3];
            sz   = (r[7:4] == 4'd0) ? 2'd3 : ((r[5:4] == 2'd3) ? 2'd2 : r[5:4]);
            a    = $urandom;
            if (r[8]) a = (sz == 2'd1) ? (a & ~32'd1) : (sz == 2'd2) ? (a & ~32'd3) : a;
            d    = $urandom;
            rd   = $urandom;
            if (both) begin
                bif.req_addr[~p] = $urandom; bif.req_size[~p] = 2'd2; bif.req_write[~p] = 1'b0;
            end
            do_txn(p, both, a, w, sz, sg, d, 32'(r[10:9]), rd);
        end

        // Slave stuck in waitrequest.
        bif.req_addr[0] = 32'h300; bif.req_size[0] = 2'd2; bif.req_write[0] = 1'b0;
        bif.req_valid = 2'b01;
        step();
        bif.req_valid = 2'b00;
        bif.waitrequest = 1'b1;
`ifdef BUS_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            chk("tmo_read_held", 32'(bif.read), 32'd1);
            step();
        end
        chk("tmo_read_drop", 32'(bif.read), 32'd0);
        chk("tmo_err", 32'(bif.resp_err), 32'd1);
        chk("tmo_valid", 32'(bif.resp_valid), oh(1'b0));
        step();
        chk("tmo_idle", 32'({bif.busy, bif.resp_valid}), 32'd0);
        bif.waitrequest = 1'b0;
`else
        for (int i = 0; i < 20; i++) begin
            chk("stall_read_held", 32'({bif.read, bif.resp_valid}), 32'b100);
            step();
        end
        bif.waitrequest = 1'b0;
        bif.readdata = 32'h0BAD_F00D;
        step();
        chk("stall_release", 32'(bif.resp_valid), oh(1'b0));
        chk("stall_rdata", bif.resp_rdata, 32'h0BAD_F00D);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
